imm_ctrl_stage: RTL and testbench

- ID-stage immediate controller for the 16-bit pipelined core.
- Decodes the opcode field (instr[15:11]) into the extender controls ZEXT and IMM_BITS, drives one imm_extender instance, and captures instruction plus extended immediate into the ID/EX boundary.
- Uses a valid/ready handshake with a one-entry skid buffer, so upstream stalls never combinationally depend on downstream ready.

---
 rtl/imm_ctrl_stage_pkg.sv | 116 +++++++++++
 rtl/imm_ctrl_stage_if.sv | 36 +++
 rtl/imm_ctrl_stage_extender.sv | 35 +++
 rtl/imm_ctrl_stage.sv | 108 ++++++++++
 tb/tb_imm_ctrl_stage.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/imm_ctrl_stage_pkg.sv
// Shared definitions for the ID-stage immediate controller: opcodes, extender widths, FSM states.
// The IMM_CTRL_ILLEGAL_EN macro adds illegal-opcode tracking to the decode result and entry.
package imm_ctrl_stage_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        IMM5  = 2'b00,
        IMM8  = 2'b01,
        IMM11 = 2'b10
    } imm_bits_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_e;

    localparam logic [4:0] OP_HALT     = 5'b00000;
    localparam logic [4:0] OP_NOP      = 5'b00001;
    localparam logic [4:0] OP_SIIC     = 5'b00010;
    localparam logic [4:0] OP_RTI      = 5'b00011;
    localparam logic [4:0] OP_J        = 5'b00100;
    localparam logic [4:0] OP_JR       = 5'b00101;
    localparam logic [4:0] OP_JAL      = 5'b00110;
    localparam logic [4:0] OP_JALR     = 5'b00111;
    localparam logic [4:0] OP_ADDI     = 5'b01000;
    localparam logic [4:0] OP_SUBI     = 5'b01001;
    localparam logic [4:0] OP_XORI     = 5'b01010;
    localparam logic [4:0] OP_ANDNI    = 5'b01011;
    localparam logic [4:0] OP_BEQZ     = 5'b01100;
    localparam logic [4:0] OP_BNEZ     = 5'b01101;
    localparam logic [4:0] OP_BLTZ     = 5'b01110;
    localparam logic [4:0] OP_BGEZ     = 5'b01111;
    localparam logic [4:0] OP_ST       = 5'b10000;
    localparam logic [4:0] OP_LD       = 5'b10001;
    localparam logic [4:0] OP_SLBI     = 5'b10010;
    localparam logic [4:0] OP_STU      = 5'b10011;
    localparam logic [4:0] OP_ROLI     = 5'b10100;
    localparam logic [4:0] OP_SLLI     = 5'b10101;
    localparam logic [4:0] OP_RORI     = 5'b10110;
    localparam logic [4:0] OP_SRLI     = 5'b10111;
    localparam logic [4:0] OP_LBI      = 5'b11000;
    localparam logic [4:0] OP_BTR      = 5'b11001;
    localparam logic [4:0] OP_SHIFT_RR = 5'b11010;
    localparam logic [4:0] OP_ALU_RR   = 5'b11011;
    localparam logic [4:0] OP_SEQ      = 5'b11100;
    localparam logic [4:0] OP_SLT      = 5'b11101;
    localparam logic [4:0] OP_SLE      = 5'b11110;
    localparam logic [4:0] OP_SCO      = 5'b11111;

    typedef struct packed {
        logic      has_imm;
        logic      zext;
        imm_bits_e imm_bits;
`ifdef IMM_CTRL_ILLEGAL_EN
        logic      illegal;
`endif
    } dec_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] imm;
        logic               has_imm;
`ifdef IMM_CTRL_ILLEGAL_EN
        logic               illegal;
`endif
    } entry_t;

    function automatic dec_t decode_op(input logic [4:0] op);
        dec_t d;
        d          = '0;
        d.imm_bits = IMM5;
        case (op)
            OP_ADDI, OP_SUBI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI,
            OP_ST, OP_LD, OP_STU: begin
                d.has_imm = 1'b1;
            end
            OP_XORI, OP_ANDNI: begin
                d.has_imm = 1'b1;
                d.zext    = 1'b1;
            end
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_LBI, OP_JR, OP_JALR: begin
                d.has_imm  = 1'b1;
                d.imm_bits = IMM8;
            end
            OP_SLBI: begin
                d.has_imm  = 1'b1;
                d.zext     = 1'b1;
                d.imm_bits = IMM8;
            end
            OP_J, OP_JAL: begin
                d.has_imm  = 1'b1;
                d.imm_bits = IMM11;
            end
            OP_HALT, OP_NOP, OP_BTR, OP_SHIFT_RR, OP_ALU_RR,
            OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                d.has_imm = 1'b0;
            end
`ifdef IMM_CTRL_ILLEGAL_EN
            OP_SIIC, OP_RTI: begin
                d.illegal = 1'b1;
            end
            default: begin
                d.illegal = 1'b1;
            end
`else
            default: begin
                d.has_imm = 1'b0;
            end
`endif
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_ctrl_stage_if.sv
// Handshake bundle between IF/ID, the immediate controller and EX.
// out_illegal is present only when IMM_CTRL_ILLEGAL_EN is defined.
interface imm_ctrl_stage_if;
    import imm_ctrl_stage_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [INSTR_W-1:0] out_imm;
    logic               out_has_imm;
`ifdef IMM_CTRL_ILLEGAL_EN
    logic               out_illegal;
`endif

    // slave is the stage itself; master is whoever surrounds it
    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_instr, out_imm, out_has_imm
`ifdef IMM_CTRL_ILLEGAL_EN
        , output out_illegal
`endif
    );

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_imm, out_has_imm
`ifdef IMM_CTRL_ILLEGAL_EN
        , input out_illegal
`endif
    );

endinterface

// File: rtl/imm_ctrl_stage_extender.sv
// Combinational immediate extender: selects a 5/8/11-bit field and sign- or zero-extends it.
// Output is forced to zero when the opcode carries no immediate.
module imm_extender
    import imm_ctrl_stage_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [10:0]   field_i,
    input  logic          zext_i,
    input  imm_bits_e     imm_bits_i,
    input  logic          en_i,
    output logic [DW-1:0] imm_o
);

    logic fill5;
    logic fill8;
    logic fill11;

    assign fill5  = ~zext_i & field_i[4];
    assign fill8  = ~zext_i & field_i[7];
    assign fill11 = ~zext_i & field_i[10];

    always_comb begin
        imm_o = '0;
        if (en_i) begin
            case (imm_bits_i)
                IMM5:    imm_o = {{(DW-5){fill5}}, field_i[4:0]};
                IMM8:    imm_o = {{(DW-8){fill8}}, field_i[7:0]};
                IMM11:   imm_o = {{(DW-11){fill11}}, field_i[10:0]};
                default: imm_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/imm_ctrl_stage.sv
// ID-stage immediate controller: decode, extend, and register into ID/EX behind a one-entry skid.
// Defining IMM_CTRL_ILLEGAL_EN adds the registered out_illegal flag.
//
// state    | meaning
// ST_EMPTY | no entry held, out_valid=0
// ST_ONE   | output register holds an entry
// ST_TWO   | output and skid both full, in_ready=0
module imm_ctrl_stage
    import imm_ctrl_stage_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_ctrl_stage_if.slave   bus
);

    dec_t          dec;
    logic [DW-1:0] ext_imm;
    entry_t        in_entry_d;

    state_e        state_q;
    entry_t        out_q;
    entry_t        skid_q;
    logic          out_valid_q;
    logic          in_ready_q;

    assign dec = decode_op(bus.in_instr[15:11]);

    imm_extender #(
        .DW (DW)
    ) u_imm_extender (
        .field_i    (bus.in_instr[10:0]),
        .zext_i     (dec.zext),
        .imm_bits_i (dec.imm_bits),
        .en_i       (dec.has_imm),
        .imm_o      (ext_imm)
    );

    always_comb begin
        in_entry_d         = '0;
        in_entry_d.instr   = bus.in_instr;
        in_entry_d.imm     = ext_imm;
        in_entry_d.has_imm = dec.has_imm;
`ifdef IMM_CTRL_ILLEGAL_EN
        in_entry_d.illegal = dec.illegal;
`endif
    end

    // in_ready_q always tracks (next state != ST_TWO), so upstream never sees a comb path from out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (bus.flush) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (bus.in_valid) begin
                        out_q       <= in_entry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (bus.in_valid && bus.out_ready) begin
                        out_q <= in_entry_d;
                    end else if (bus.in_valid) begin
                        skid_q     <= in_entry_d;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_TWO;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (bus.out_ready) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_ONE;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_q.instr;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_has_imm = out_q.has_imm;
`ifdef IMM_CTRL_ILLEGAL_EN
    assign bus.out_illegal = out_q.illegal;
`endif

endmodule

// File: tb/tb_imm_ctrl_stage.sv
// Directed plus randomized bench for imm_ctrl_stage with a queue scoreboard of held entries.
module tb_imm_ctrl_stage;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;
        logic        has_imm;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    imm_ctrl_stage_if bus();

    imm_ctrl_stage #(.DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t ref_model(input logic [15:0] i);
        exp_t e;
        e.instr   = i;
        e.imm     = 16'h0000;
        e.has_imm = 1'b1;
        e.illegal = (i[15:11] == 5'b00010) || (i[15:11] == 5'b00011);
        case (i[15:11])
            5'b01000, 5'b01001, 5'b10100, 5'b10101, 5'b10110, 5'b10111,
            5'b10000, 5'b10001, 5'b10011: e.imm = {{11{i[4]}}, i[4:0]};
            5'b01010, 5'b01011:           e.imm = {11'b0, i[4:0]};
            5'b01100, 5'b01101, 5'b01110, 5'b01111,
            5'b11000, 5'b00101, 5'b00111: e.imm = {{8{i[7]}}, i[7:0]};
            5'b10010:                     e.imm = {8'b0, i[7:0]};
            5'b00100, 5'b00110:           e.imm = {{5{i[10]}}, i[10:0]};
            default:                      e.has_imm = 1'b0;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // compare DUT against scoreboard, then advance the scoreboard by one clock edge
    task automatic tick();
        bit can_acc;
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, q.size() < 2});
        if (q.size() > 0) begin
            chk("out_instr", {16'b0, bus.out_instr}, {16'b0, q[0].instr});
            chk("out_imm", {16'b0, bus.out_imm}, {16'b0, q[0].imm});
            chk("out_has_imm", {31'b0, bus.out_has_imm}, {31'b0, q[0].has_imm});
`ifdef IMM_CTRL_ILLEGAL_EN
            chk("out_illegal", {31'b0, bus.out_illegal}, {31'b0, q[0].illegal});
`endif
        end
        if (bus.flush) begin
            q.delete();
        end else begin
            can_acc = q.size() < 2;
            if (bus.out_ready && q.size() > 0) void'(q.pop_front());
            if (bus.in_valid && can_acc) q.push_back(ref_model(bus.in_instr));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [15:0] instr, input logic ordy);
        bus.in_valid  = 1'b1;
        bus.in_instr  = instr;
        bus.out_ready = ordy;
        tick();
    endtask

    task automatic idle(input logic ordy);
        bus.in_valid  = 1'b0;
        bus.out_ready = ordy;
        tick();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 16'h0000;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_instr", {16'b0, bus.out_instr}, 32'h0);
        chk("rst_out_imm", {16'b0, bus.out_imm}, 32'h0);
        chk("rst_has_imm", {31'b0, bus.out_has_imm}, 32'h0);
        idle(1'b1);

        // one-cycle latency, extension variants
        offer(16'h401F, 1'b1);
        offer(16'h501F, 1'b1);
        offer(16'hC080, 1'b1);
        offer(16'h9080, 1'b1);
        offer(16'h2400, 1'b1);
        offer(16'hD800, 1'b1);
        offer(16'h1000, 1'b1);
        offer(16'h3FFF, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // back-pressure: second instruction lands in skid, third is refused
        offer(16'h4811, 1'b0);
        offer(16'h6C7F, 1'b0);
        offer(16'hA5A5, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // flush while in ST_TWO with a same-cycle offer
        offer(16'h4001, 1'b0);
        offer(16'h4002, 1'b0);
        bus.flush = 1'b1;
        offer(16'h4003, 1'b1);
        bus.flush = 1'b0;
        idle(1'b1);
        idle(1'b1);

        for (int n = 0; n < 200; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_instr  = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 24) == 0);
            tick();
        end
        bus.flush = 1'b0;

        // asynchronous reset mid-transfer
        offer(16'h4415, 1'b0);
        offer(16'hC0FE, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("arst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        chk("arst_out_imm", {16'b0, bus.out_imm}, 32'h0);
        chk("arst_out_instr", {16'b0, bus.out_instr}, 32'h0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        offer(16'h7A80, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
